pipelined_decode_stage: RTL
===========================

PIPELINED_DECODE_STAGE -- requirements
Module: pipelined_decode_stage

Interface
REQ-001 Parameter WIDTH, 16, register/data width.
REQ-002 Parameter N_REGS, 8, register count (power of two, >=2); AW = clog2(N_REGS).
REQ-003 Parameter IMM_W, 16, fetch word and raw immediate width; requires 5+3*AW <= IMM_W.
REQ-004 Parameter SIGN_EXT, 1, immediate extension mode (1 sign, 0 zero).
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 if_valid  in  1  fetch word present; if_word  in  IMM_W  instruction or immediate word.
REQ-008 id_ready  out  1  word accepted on the cycle when if_valid && id_ready.
REQ-009 flush  in  1  squash decode state and ID/EX contents.
REQ-010 wb_en  in  1, wb_addr  in  AW, wb_data  in  WIDTH  register write-back port.
REQ-011 ex_ready  in  1  execute accepts ID/EX contents.
REQ-012 ex_valid  out  1; ex_alu_op  out  3; ex_alu_src_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal  out  1 each.
REQ-013 ex_rd, ex_rs1, ex_rs2  out  AW; ex_a, ex_b, ex_imm  out  WIDTH  (rs1 value, rs2 value, extended immediate).

Function
REQ-014 Instruction = if_word[5+3*AW-1:0]: opcode [top 5 bits], then rd, rs1, rs2 (AW bits each, MSB to LSB).
REQ-015 Opcodes: 00000 NOP; 01fff reg-reg ALU (alu_op=fff, reg_write); 10fff imm ALU (alu_op=fff, alu_src_imm, reg_write); 11000 LDD (alu_op=000, alu_src_imm, mem_read, mem_to_reg, reg_write); 11001 STD (alu_op=000, alu_src_imm, mem_write); all others illegal.
REQ-016 10fff, LDD and STD are two-word; the following accepted word is the immediate, low IMM_W bits used.
REQ-017 FSM states S_OP, S_IMM; S_OP accepting a two-word opcode latches it and moves to S_IMM; S_IMM accepting a word issues the latched instruction and returns to S_OP.
REQ-018 ID/EX register advances when !ex_valid || ex_ready; it holds all ex_* outputs unchanged otherwise.
REQ-019 Issue point: S_OP with one-word opcode, or S_IMM; issue occurs on an accepted word at the issue point and loads ID/EX with ex_valid=1, latency 1 cycle.
REQ-020 NOP is consumed and loads a bubble (ex_valid=0).
REQ-021 Illegal opcode issues ex_valid=1, ex_illegal=1, all write/mem enables 0.
REQ-022 Register file N_REGS x WIDTH, written at clock edge when wb_en; no hard-wired zero register.
REQ-023 Reads are combinational at issue; a same-cycle wb_en to the read address returns wb_data (write-through bypass).
REQ-024 Immediate extended to WIDTH per SIGN_EXT, truncated to low WIDTH bits when WIDTH < IMM_W; ex_imm = 0 for one-word instructions.
REQ-025 Load-use hazard: ex_valid && ex_mem_read && ex_rd equals rs1 (any non-NOP) or rs2 (reg-reg, STD) of the instruction at the issue point.
REQ-026 During hazard id_ready=0; if ID/EX advances it loads a bubble; hazard clears after one advance.
REQ-027 id_ready = advance && !hazard in both states; a two-word first word is accepted only under the same condition.
REQ-028 flush: next edge clears ex_valid and all enables, FSM to S_OP, discards latched opcode and any word accepted that cycle; wb write still performed.
REQ-029 Priority: rst > flush > hazard > normal operation.

Reset
REQ-030 rst: all registers zero, FSM S_OP, all ex_* outputs 0, id_ready 0 while rst high.
REQ-031 Reset mid two-word instruction discards the latched opcode; no issue follows.

Verification
REQ-032 After reset write r3=0x0005, r4=0x0007; issue 01000/rd=1/rs1=3/rs2=4 -> next cycle ex_valid=1, alu_op=000, ex_a=0x0005, ex_b=0x0007, reg_write=1.
REQ-033 Issue 10010 rd=2 rs1=1, immediate word 0xFFF0 -> ex_imm=0xFFF0 (SIGN_EXT=1, WIDTH=16); S_IMM observed between words; id_ready high throughout.
REQ-034 LDD rd=5, then reg-reg rs1=5 -> one bubble (ex_valid=0), id_ready low one cycle, then dependent instruction issues.
REQ-035 ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* stable, id_ready=0; resumes on ex_ready=1 with no lost or duplicated word.
REQ-036 flush asserted while in S_IMM -> ex_valid=0 next cycle, FSM S_OP, next word decoded as opcode.
REQ-037 wb_en r6=0xABCD same cycle as issue reading rs1=6 -> ex_a=0xABCD; opcode 11111 -> ex_illegal=1, enables 0.

Source files
------------

// File: rtl/pipelined_decode_stage.sv
// Decode stage: two-word instruction FSM, register file with write-through,
// load-use interlock and a stallable ID/EX register.
module pipelined_decode_stage #(
    parameter int WIDTH    = 16,
    parameter int N_REGS   = 8,
    parameter int IMM_W    = 16,
    parameter int SIGN_EXT = 1,
    localparam int AW      = $clog2(N_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [IMM_W-1:0] if_word,
    output logic             id_ready,
    input  logic             flush,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             ex_ready,
    output logic             ex_valid,
    output logic [2:0]       ex_alu_op,
    output logic             ex_alu_src_imm,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             ex_illegal,
    output logic [AW-1:0]    ex_rd,
    output logic [AW-1:0]    ex_rs1,
    output logic [AW-1:0]    ex_rs2,
    output logic [WIDTH-1:0] ex_a,
    output logic [WIDTH-1:0] ex_b,
    output logic [WIDTH-1:0] ex_imm
);
    localparam int IW = 5 + 3 * AW;

    typedef enum logic {S_OP, S_IMM} state_t;

    typedef struct packed {
        logic             valid;
        logic [2:0]       alu_op;
        logic             src_imm;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             mem_to_reg;
        logic             illegal;
        logic [AW-1:0]    rd;
        logic [AW-1:0]    rs1;
        logic [AW-1:0]    rs2;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] imm;
    } idex_t;

    state_t           state_q;
    logic [IW-1:0]    op_q;
    idex_t            idex_q, idex_d;
    logic [WIDTH-1:0] rf_q [N_REGS];

    logic [IW-1:0]    instr;
    logic [4:0]       opc;
    logic [AW-1:0]    rd, rs1, rs2;
    logic             present, hazard, advance, accept, issue;
    logic             is_nop, is_two, uses_rs2;
    logic [2:0]       d_alu_op;
    logic             d_src_imm, d_rw, d_mr, d_mw, d_m2r, d_ill;
    logic [WIDTH-1:0] rv1, rv2, imm_s, imm_u, imm_ext;

    // In S_IMM the latched opcode sits at the issue point, not the fetch word
    assign instr   = (state_q == S_IMM) ? op_q : if_word[IW-1:0];
    assign opc     = instr[IW-1 -: 5];
    assign rd      = instr[3*AW-1 -: AW];
    assign rs1     = instr[2*AW-1 -: AW];
    assign rs2     = instr[AW-1:0];
    assign present = (state_q == S_IMM) || if_valid;

    always_comb begin
        d_alu_op  = 3'b000;
        d_src_imm = 1'b0;
        d_rw      = 1'b0;
        d_mr      = 1'b0;
        d_mw      = 1'b0;
        d_m2r     = 1'b0;
        d_ill     = 1'b0;
        is_nop    = 1'b0;
        is_two    = 1'b0;
        unique case (1'b1)
            opc == 5'b00000: is_nop = 1'b1;
            opc[4:3] == 2'b01: begin
                d_alu_op = opc[2:0];
                d_rw     = 1'b1;
            end
            opc[4:3] == 2'b10: begin
                d_alu_op  = opc[2:0];
                d_src_imm = 1'b1;
                d_rw      = 1'b1;
                is_two    = 1'b1;
            end
            opc == 5'b11000: begin
                d_src_imm = 1'b1;
                d_mr      = 1'b1;
                d_m2r     = 1'b1;
                d_rw      = 1'b1;
                is_two    = 1'b1;
            end
            opc == 5'b11001: begin
                d_src_imm = 1'b1;
                d_mw      = 1'b1;
                is_two    = 1'b1;
            end
            default: d_ill = 1'b1;
        endcase
    end

    assign uses_rs2 = (opc[4:3] == 2'b01) || (opc == 5'b11001);
    assign hazard   = present && idex_q.valid && idex_q.mem_read &&
                      ((!is_nop && idex_q.rd == rs1) ||
                       (uses_rs2 && idex_q.rd == rs2));
    assign advance  = !idex_q.valid || ex_ready;
    assign id_ready = !rst && advance && !hazard;
    assign accept   = if_valid && id_ready;
    assign issue    = accept && !is_nop && ((state_q == S_IMM) || !is_two);

    assign rv1 = (wb_en && wb_addr == rs1) ? wb_data : rf_q[rs1];
    assign rv2 = (wb_en && wb_addr == rs2) ? wb_data : rf_q[rs2];

    assign imm_s   = WIDTH'($signed(if_word));
    assign imm_u   = WIDTH'(if_word);
    assign imm_ext = (SIGN_EXT != 0) ? imm_s : imm_u;

    always_comb begin
        idex_d = idex_q;
        if (flush) begin
            idex_d = '0;
        end else if (advance) begin
            idex_d = '0;
            if (issue) begin
                idex_d.valid      = 1'b1;
                idex_d.alu_op     = d_alu_op;
                idex_d.src_imm    = d_src_imm;
                idex_d.reg_write  = d_rw;
                idex_d.mem_read   = d_mr;
                idex_d.mem_write  = d_mw;
                idex_d.mem_to_reg = d_m2r;
                idex_d.illegal    = d_ill;
                idex_d.rd         = rd;
                idex_d.rs1        = rs1;
                idex_d.rs2        = rs2;
                idex_d.a          = rv1;
                idex_d.b          = rv2;
                idex_d.imm        = (state_q == S_IMM) ? imm_ext : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_OP;
            op_q    <= '0;
            idex_q  <= '0;
        end else begin
            idex_q <= idex_d;
            if (flush) begin
                state_q <= S_OP;
                op_q    <= '0;
            end else if (accept) begin
                if (state_q == S_IMM) begin
                    state_q <= S_OP;
                end else if (is_two) begin
                    state_q <= S_IMM;
                    op_q    <= instr;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REGS; i++) rf_q[i] <= '0;
        end else if (wb_en) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    assign ex_valid       = idex_q.valid;
    assign ex_alu_op      = idex_q.alu_op;
    assign ex_alu_src_imm = idex_q.src_imm;
    assign ex_reg_write   = idex_q.reg_write;
    assign ex_mem_read    = idex_q.mem_read;
    assign ex_mem_write   = idex_q.mem_write;
    assign ex_mem_to_reg  = idex_q.mem_to_reg;
    assign ex_illegal     = idex_q.illegal;
    assign ex_rd          = idex_q.rd;
    assign ex_rs1         = idex_q.rs1;
    assign ex_rs2         = idex_q.rs2;
    assign ex_a           = idex_q.a;
    assign ex_b           = idex_q.b;
    assign ex_imm         = idex_q.imm;

endmodule
